// File: rtl/axil_strobe_xbar.sv
// AXI-Lite slave to N-channel strobe/ack register-bus crossbar.
// One access in flight at a time; the channel is taken from a word-address field,
// unmapped channels answer DECERR and a stalled ack answers SLVERR after TIMEOUT cycles.
module axil_strobe_xbar #(
  parameter int unsigned N_CHAN   = 4,
  parameter int unsigned SEL_LSB  = 12,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned LOC_W    = 12,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                  axilClk,
  input  logic                  axilRst,
  // write address / data / response
  input  logic [31:0]           axilWriteMaster_awaddr,
  input  logic                  axilWriteMaster_awvalid,
  output logic                  axilWriteSlave_awready,
  input  logic [31:0]           axilWriteMaster_wdata,
  input  logic [3:0]            axilWriteMaster_wstrb,
  input  logic                  axilWriteMaster_wvalid,
  output logic                  axilWriteSlave_wready,
  output logic [1:0]            axilWriteSlave_bresp,
  output logic                  axilWriteSlave_bvalid,
  input  logic                  axilWriteMaster_bready,
  // read address / data
  input  logic [31:0]           axilReadMaster_araddr,
  input  logic                  axilReadMaster_arvalid,
  output logic                  axilReadSlave_arready,
  output logic [31:0]           axilReadSlave_rdata,
  output logic [1:0]            axilReadSlave_rresp,
  output logic                  axilReadSlave_rvalid,
  input  logic                  axilReadMaster_rready,
  // strobe/ack channels
  output logic [N_CHAN-1:0]     ch_wstr,
  output logic [N_CHAN-1:0]     ch_rstr,
  input  logic [N_CHAN-1:0]     ch_wack,
  input  logic [N_CHAN-1:0]     ch_rack,
  output logic [LOC_W-1:0]      ch_addr,
  output logic [31:0]           ch_wdata,
  output logic [3:0]            ch_wstrb,
  input  logic [32*N_CHAN-1:0]  ch_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_ACC = 3'd1,
    WR_RSP = 3'd2,
    RD_ACC = 3'd3,
    RD_RSP = 3'd4
  } state_t;

  state_t             state;
  logic               last_wr;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt;

  logic [SEL_W-1:0]   aw_sel_c;
  logic [SEL_W-1:0]   ar_sel_c;
  logic               aw_unmapped_c;
  logic               ar_unmapped_c;
  logic               wr_elig_c;
  logic               rd_elig_c;
  logic               grant_rd_c;
  logic               grant_wr_c;
  logic [N_CHAN-1:0]  sel_onehot_c;
  logic               sel_wack_c;
  logic               sel_rack_c;
  logic [31:0]        sel_rdata_c;
  logic               timeout_c;
  logic               unused_addr;

  // Channel-select field and local address come from the word address (byte address >> 2).
  assign aw_sel_c      = axilWriteMaster_awaddr[2+SEL_LSB +: SEL_W];
  assign ar_sel_c      = axilReadMaster_araddr[2+SEL_LSB +: SEL_W];
  assign aw_unmapped_c = 32'(aw_sel_c) >= N_CHAN;
  assign ar_unmapped_c = 32'(ar_sel_c) >= N_CHAN;
  assign unused_addr   = ^{axilWriteMaster_awaddr, axilReadMaster_araddr};

  // Alternate between read and write when both are waiting; the first tie after reset goes to read.
  assign wr_elig_c  = axilWriteMaster_awvalid & axilWriteMaster_wvalid;
  assign rd_elig_c  = axilReadMaster_arvalid;
  assign grant_rd_c = rd_elig_c & (~wr_elig_c | last_wr);
  assign grant_wr_c = wr_elig_c & ~grant_rd_c;

  assign sel_onehot_c = N_CHAN'(1) << sel_q;
  assign timeout_c    = (cnt == CNT_LAST);

  // Pick the ack and read data of the selected channel only.
  always_comb begin
    sel_wack_c  = 1'b0;
    sel_rack_c  = 1'b0;
    sel_rdata_c = '0;
    for (int unsigned k = 0; k < N_CHAN; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_wack_c  = ch_wack[k];
        sel_rack_c  = ch_rack[k];
        sel_rdata_c = ch_rdata[32*k +: 32];
      end
    end
  end

  // Access sequencer: grant, strobe until ack or timeout, then hold the response until accepted.
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      state                  <= IDLE;
      last_wr                <= 1'b1;
      sel_q                  <= '0;
      cnt                    <= '0;
      axilWriteSlave_awready <= 1'b0;
      axilWriteSlave_wready  <= 1'b0;
      axilWriteSlave_bresp   <= RESP_OKAY;
      axilWriteSlave_bvalid  <= 1'b0;
      axilReadSlave_arready  <= 1'b0;
      axilReadSlave_rdata    <= '0;
      axilReadSlave_rresp    <= RESP_OKAY;
      axilReadSlave_rvalid   <= 1'b0;
      ch_wstr                <= '0;
      ch_rstr                <= '0;
      ch_addr                <= '0;
      ch_wdata               <= '0;
      ch_wstrb               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr_c) begin
            axilWriteSlave_awready <= 1'b1;
            axilWriteSlave_wready  <= 1'b1;
            last_wr                <= 1'b1;
            sel_q                  <= aw_sel_c;
            ch_addr                <= axilWriteMaster_awaddr[2 +: LOC_W];
            ch_wdata               <= axilWriteMaster_wdata;
            ch_wstrb               <= axilWriteMaster_wstrb;
            state                  <= aw_unmapped_c ? WR_RSP : WR_ACC;
          end else if (grant_rd_c) begin
            axilReadSlave_arready  <= 1'b1;
            last_wr                <= 1'b0;
            sel_q                  <= ar_sel_c;
            ch_addr                <= axilReadMaster_araddr[2 +: LOC_W];
            state                  <= ar_unmapped_c ? RD_RSP : RD_ACC;
          end
        end

        WR_ACC: begin
          if (axilWriteSlave_awready) begin
            axilWriteSlave_awready <= 1'b0;
            axilWriteSlave_wready  <= 1'b0;
            ch_wstr                <= sel_onehot_c;
          end else if (sel_wack_c) begin
            ch_wstr               <= '0;
            cnt                   <= '0;
            axilWriteSlave_bresp  <= RESP_OKAY;
            axilWriteSlave_bvalid <= 1'b1;
            state                 <= WR_RSP;
          end else if (timeout_c) begin
            ch_wstr               <= '0;
            cnt                   <= '0;
            axilWriteSlave_bresp  <= RESP_SLVERR;
            axilWriteSlave_bvalid <= 1'b1;
            state                 <= WR_RSP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WR_RSP: begin
          if (axilWriteSlave_awready) begin
            // unmapped channel: no strobe, answer straight away
            axilWriteSlave_awready <= 1'b0;
            axilWriteSlave_wready  <= 1'b0;
            axilWriteSlave_bresp   <= RESP_DECERR;
            axilWriteSlave_bvalid  <= 1'b1;
          end else if (axilWriteMaster_bready) begin
            axilWriteSlave_bvalid <= 1'b0;
            state                 <= IDLE;
          end
        end

        RD_ACC: begin
          if (axilReadSlave_arready) begin
            axilReadSlave_arready <= 1'b0;
            ch_rstr               <= sel_onehot_c;
          end else if (sel_rack_c) begin
            ch_rstr              <= '0;
            cnt                  <= '0;
            axilReadSlave_rdata  <= sel_rdata_c;
            axilReadSlave_rresp  <= RESP_OKAY;
            axilReadSlave_rvalid <= 1'b1;
            state                <= RD_RSP;
          end else if (timeout_c) begin
            ch_rstr              <= '0;
            cnt                  <= '0;
            axilReadSlave_rdata  <= ERR_DATA;
            axilReadSlave_rresp  <= RESP_SLVERR;
            axilReadSlave_rvalid <= 1'b1;
            state                <= RD_RSP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RD_RSP: begin
          if (axilReadSlave_arready) begin
            axilReadSlave_arready <= 1'b0;
            axilReadSlave_rdata   <= ERR_DATA;
            axilReadSlave_rresp   <= RESP_DECERR;
            axilReadSlave_rvalid  <= 1'b1;
          end else if (axilReadMaster_rready) begin
            axilReadSlave_rvalid <= 1'b0;
            state                <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
